boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl_pkg.sv | 17 +
 rtl/boot_loader_ctrl_if.sv | 27 ++
 rtl/boot_loader_ctrl_word_pack.sv | 46 ++++
 rtl/boot_loader_ctrl.sv | 154 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the TCM boot loader.
package boot_loader_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    localparam int unsigned BOOT_HDR_BYTES = 12;
    localparam int unsigned BOOT_TCM_BYTES = 65536;

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Byte-stream input and TCM data-port write request bundle of the boot loader.
interface boot_loader_ctrl_if;

    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;

    logic [31:0] mem_d_addr_o;
    logic [31:0] mem_d_data_wr_o;
    logic [3:0]  mem_d_wr_o;
    logic        mem_d_accept_i;
    logic        mem_d_ack_i;
    logic        mem_d_error_i;

    // master: the loader side
    modport master (
        input  in_valid_i, in_data_i, mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
        output in_ready_o, mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o
    );

    // slave: byte source and TCM side
    modport slave (
        output in_valid_i, in_data_i, mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
        input  in_ready_o, mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o
    );

endinterface

// File: rtl/boot_loader_ctrl_word_pack.sv
// Byte-to-word lane packer; word_o/strb_o already include the byte pushed this cycle.
module boot_word_pack (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [3:0]  strb_o
);

    logic [31:0] word_q, word_d;
    logic [3:0]  strb_q, strb_d;
    logic [1:0]  lane_q, lane_d;

    always_comb begin
        word_d = word_q;
        strb_d = strb_q;
        lane_d = lane_q;
        if (clear_i) begin
            word_d = '0;
            strb_d = '0;
            lane_d = '0;
        end else if (push_i) begin
            word_d[{lane_q, 3'b000} +: 8] = byte_i;
            strb_d[lane_q]                = 1'b1;
            lane_d                        = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            strb_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            strb_q <= strb_d;
            lane_q <= lane_d;
        end
    end

    assign word_o = word_d;
    assign strb_o = strb_d;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Streams a header plus payload image into the TCM and then releases the core from reset.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int unsigned TCM_BYTES = BOOT_TCM_BYTES,
    parameter int unsigned HDR_BYTES = BOOT_HDR_BYTES
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    boot_loader_ctrl_if.master bus,
    output logic               own_o,
    output logic               core_rst_o,
    output logic [31:0]        boot_pc_o,
    output logic               done_o,
    output logic               error_o
);

    boot_state_t state_q;
    logic [3:0]  hdr_cnt_q;
    logic [31:0] base_q, len_q, remaining_q, waddr_q;
    logic [31:0] boot_pc_q, addr_q, wdata_q;
    logic [3:0]  wr_q;
    logic        in_ready_q, own_q, core_rst_q, done_q, error_q;

    logic        in_xfer, hdr_last, hdr_bad, last_byte, ack_evt;
    logic [32:0] hdr_end;
    logic [31:0] pack_word;
    logic [3:0]  pack_strb;

    assign in_xfer   = bus.in_valid_i & in_ready_q;
    assign hdr_last  = (hdr_cnt_q == 4'(HDR_BYTES - 1));
    assign hdr_end   = {1'b0, base_q} + {1'b0, len_q};
    assign hdr_bad   = (base_q[1:0] != 2'b00) || (hdr_end > 33'(TCM_BYTES));
    assign last_byte = pack_strb[3] || (remaining_q == 32'd1);
    // An ack in the same cycle as accept completes the write without visiting WAIT_ACK.
    assign ack_evt   = bus.mem_d_ack_i &
                       ((state_q == ST_WAIT_ACK) | ((state_q == ST_WRITE) & bus.mem_d_accept_i));

    boot_word_pack u_pack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (state_q != ST_DATA),
        .push_i  (in_xfer && (state_q == ST_DATA)),
        .byte_i  (bus.in_data_i),
        .word_o  (pack_word),
        .strb_o  (pack_strb)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= '0;
            base_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            waddr_q     <= '0;
            boot_pc_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= '0;
            in_ready_q  <= 1'b0;
            own_q       <= 1'b0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_HDR;
                        hdr_cnt_q  <= '0;
                        in_ready_q <= 1'b1;
                        own_q      <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (in_xfer) begin
                        hdr_cnt_q <= hdr_cnt_q + 4'd1;
                        case (hdr_cnt_q[3:2])
                            2'd0:    base_q[{hdr_cnt_q[1:0], 3'b000} +: 8]    <= bus.in_data_i;
                            2'd1:    len_q[{hdr_cnt_q[1:0], 3'b000} +: 8]     <= bus.in_data_i;
                            default: boot_pc_q[{hdr_cnt_q[1:0], 3'b000} +: 8] <= bus.in_data_i;
                        endcase
                        if (hdr_last) begin
                            remaining_q <= len_q;
                            waddr_q     <= base_q;
                            if (hdr_bad) begin
                                state_q    <= ST_ERROR;
                                error_q    <= 1'b1;
                                own_q      <= 1'b0;
                                in_ready_q <= 1'b0;
                            end else if (len_q == '0) begin
                                state_q    <= ST_DONE;
                                done_q     <= 1'b1;
                                own_q      <= 1'b0;
                                in_ready_q <= 1'b0;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (in_xfer) begin
                        remaining_q <= remaining_q - 32'd1;
                        if (last_byte) begin
                            state_q    <= ST_WRITE;
                            in_ready_q <= 1'b0;
                            wr_q       <= pack_strb;
                            wdata_q    <= pack_word;
                            addr_q     <= waddr_q;
                        end
                    end
                end
                ST_WRITE, ST_WAIT_ACK: begin
                    if ((state_q == ST_WRITE) && bus.mem_d_accept_i) begin
                        state_q <= ST_WAIT_ACK;
                        wr_q    <= '0;
                        waddr_q <= waddr_q + 32'd4;
                    end
                    if (ack_evt) begin
                        if (bus.mem_d_error_i) begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                            own_q   <= 1'b0;
                        end else if (remaining_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            own_q   <= 1'b0;
                        end else begin
                            state_q    <= ST_DATA;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE:  core_rst_q <= 1'b0;
                ST_ERROR: core_rst_q <= 1'b1;
                default:  state_q    <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o      = in_ready_q;
    assign bus.mem_d_addr_o    = addr_q;
    assign bus.mem_d_data_wr_o = wdata_q;
    assign bus.mem_d_wr_o      = wr_q;
    assign own_o               = own_q;
    assign core_rst_o          = core_rst_q;
    assign boot_pc_o           = boot_pc_q;
    assign done_o              = done_q;
    assign error_o             = error_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl with a configurable-latency TCM responder.
module tb_boot_loader_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        own, core_rst, done, err;
    logic [31:0] boot_pc;

    boot_loader_ctrl_if bus();

    boot_loader_ctrl #(
        .TCM_BYTES (65536),
        .HDR_BYTES (12)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .bus        (bus),
        .own_o      (own),
        .core_rst_o (core_rst),
        .boot_pc_o  (boot_pc),
        .done_o     (done),
        .error_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // TCM responder: accept after acc_dly cycles, ack ack_dly cycles after accept
    int          acc_dly = 0;
    int          ack_dly = 0;
    bit          ack_err = 1'b0;
    int          acc_cnt, ack_cnt;
    bit          in_req = 1'b0;
    bit          pend_ack = 1'b0;
    logic [31:0] hold_addr, hold_data;
    logic [3:0]  hold_strb;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  ws[$];

    always @(negedge clk) begin
        bus.mem_d_accept_i = 1'b0;
        bus.mem_d_ack_i    = 1'b0;
        bus.mem_d_error_i  = 1'b0;
        if (!rst_n) begin
            in_req   = 1'b0;
            pend_ack = 1'b0;
        end else begin
            if (in_req || pend_ack)
                check("ready_low_busy", 32'(bus.in_ready_o), 32'd0);
            if (pend_ack) begin
                check("one_outstanding", 32'(bus.mem_d_wr_o), 32'd0);
                if (ack_cnt >= ack_dly) begin
                    bus.mem_d_ack_i   = 1'b1;
                    bus.mem_d_error_i = ack_err;
                    pend_ack          = 1'b0;
                end else begin
                    ack_cnt++;
                end
            end else if (bus.mem_d_wr_o != 4'h0) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    acc_cnt   = 0;
                    hold_addr = bus.mem_d_addr_o;
                    hold_data = bus.mem_d_data_wr_o;
                    hold_strb = bus.mem_d_wr_o;
                end else begin
                    check("req_addr_stable", bus.mem_d_addr_o, hold_addr);
                    check("req_data_stable", bus.mem_d_data_wr_o, hold_data);
                    check("req_strb_stable", 32'(bus.mem_d_wr_o), 32'(hold_strb));
                end
                if (acc_cnt >= acc_dly) begin
                    bus.mem_d_accept_i = 1'b1;
                    wa.push_back(bus.mem_d_addr_o);
                    wd.push_back(bus.mem_d_data_wr_o);
                    ws.push_back(bus.mem_d_wr_o);
                    in_req = 1'b0;
                    if (ack_dly == 0) begin
                        bus.mem_d_ack_i   = 1'b1;
                        bus.mem_d_error_i = ack_err;
                    end else begin
                        pend_ack = 1'b1;
                        ack_cnt  = 1;
                    end
                end else begin
                    acc_cnt++;
                end
            end
        end
    end

    logic [7:0] stream[$];

    task automatic load_image(input logic [31:0] base, input logic [31:0] len,
                              input logic [31:0] entry, input int npay,
                              input logic [7:0] first, input logic [7:0] step);
        logic [7:0] b;
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(base[8*i +: 8]);
        for (int i = 0; i < 4; i++) stream.push_back(len[8*i +: 8]);
        for (int i = 0; i < 4; i++) stream.push_back(entry[8*i +: 8]);
        b = first;
        for (int i = 0; i < npay; i++) begin
            stream.push_back(b);
            b = b + step;
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        ws.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        start           = 1'b0;
        bus.in_valid_i  = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stream(input bit keep_valid);
        int idx = 0;
        int guard = 0;
        while (idx < stream.size() && guard < 500) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = stream[idx];
            if (bus.in_ready_o) idx++;
            guard++;
        end
        @(negedge clk);
        if (keep_valid) bus.in_data_i = 8'hA5;
        else bus.in_valid_i = 1'b0;
        check("send_all_bytes", 32'(idx), 32'(stream.size()));
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", 32'(done | err), 32'd1);
    endtask

    task automatic check_write(input int i, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        if (i < wa.size()) begin
            check($sformatf("wr%0d_addr", i), wa[i], a);
            check($sformatf("wr%0d_data", i), wd[i], d);
            check($sformatf("wr%0d_strb", i), 32'(ws[i]), 32'(s));
        end else begin
            check($sformatf("wr%0d_present", i), 32'(wa.size()), 32'(i + 1));
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_core_rst"}, 32'(core_rst), 32'd1);
        check({pfx, "_own"}, 32'(own), 32'd0);
        check({pfx, "_wr"}, 32'(bus.mem_d_wr_o), 32'd0);
        check({pfx, "_ready"}, 32'(bus.in_ready_o), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_error"}, 32'(err), 32'd0);
        check({pfx, "_pc"}, boot_pc, 32'd0);
        check({pfx, "_addr"}, bus.mem_d_addr_o, 32'd0);
        check({pfx, "_data"}, bus.mem_d_data_wr_o, 32'd0);
    endtask

    task automatic run_basic_image(input string pfx);
        load_image(32'h100, 32'd8, 32'h100, 8, 8'h11, 8'h11);
        pulse_start();
        check({pfx, "_own_on"}, 32'(own), 32'd1);
        send_stream(1'b0);
        wait_end(100);
        check({pfx, "_done"}, 32'(done), 32'd1);
        check({pfx, "_core_rst_entry"}, 32'(core_rst), 32'd1);
        @(negedge clk);
        check({pfx, "_core_rst_rel"}, 32'(core_rst), 32'd0);
        check({pfx, "_own_off"}, 32'(own), 32'd0);
        check({pfx, "_pc"}, boot_pc, 32'h100);
        check({pfx, "_nwr"}, 32'(wa.size()), 32'd2);
        check_write(0, 32'h100, 32'h44332211, 4'hF);
        check_write(1, 32'h104, 32'h88776655, 4'hF);
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        bus.in_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(bus.in_ready_o), 32'd0);
        check("idle_own", 32'(own), 32'd0);
        bus.in_valid_i = 1'b0;

        // Two full words, immediate responses
        run_basic_image("t1");
        pulse_start();
        check("t1_start_ignored_done", 32'(done), 32'd1);
        check("t1_start_ignored_own", 32'(own), 32'd0);

        // Partial final word
        do_reset();
        load_image(32'h0, 32'd5, 32'h0, 5, 8'hAA, 8'h11);
        pulse_start();
        send_stream(1'b0);
        wait_end(100);
        check("t2_done", 32'(done), 32'd1);
        check("t2_nwr", 32'(wa.size()), 32'd2);
        check_write(0, 32'h0, 32'hDDCCBBAA, 4'hF);
        check_write(1, 32'h4, 32'h000000EE, 4'h1);

        // Misaligned base
        do_reset();
        load_image(32'h2, 32'd4, 32'h0, 0, 8'h00, 8'h00);
        pulse_start();
        send_stream(1'b0);
        wait_end(50);
        repeat (2) @(negedge clk);
        check("t3_error", 32'(err), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_nwr", 32'(wa.size()), 32'd0);
        check("t3_core_rst", 32'(core_rst), 32'd1);
        check("t3_own", 32'(own), 32'd0);
        check("t3_ready", 32'(bus.in_ready_o), 32'd0);

        // Image overruns the TCM
        do_reset();
        load_image(32'hFFFC, 32'd8, 32'h0, 0, 8'h00, 8'h00);
        pulse_start();
        send_stream(1'b0);
        wait_end(50);
        check("t4a_error", 32'(err), 32'd1);
        check("t4a_nwr", 32'(wa.size()), 32'd0);

        // Image ends exactly at the top of the TCM
        do_reset();
        load_image(32'hFFFC, 32'd4, 32'h0, 4, 8'h01, 8'h01);
        pulse_start();
        send_stream(1'b0);
        wait_end(50);
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_error", 32'(err), 32'd0);
        check("t4b_nwr", 32'(wa.size()), 32'd1);
        check_write(0, 32'hFFFC, 32'h04030201, 4'hF);

        // Empty payload
        do_reset();
        load_image(32'h10, 32'd0, 32'hDEADBEEF, 0, 8'h00, 8'h00);
        pulse_start();
        send_stream(1'b0);
        wait_end(50);
        check("t4c_done", 32'(done), 32'd1);
        check("t4c_nwr", 32'(wa.size()), 32'd0);
        check("t4c_pc", boot_pc, 32'hDEADBEEF);

        // Slow accept and ack, valid held high throughout
        do_reset();
        acc_dly = 3;
        ack_dly = 2;
        load_image(32'h200, 32'd6, 32'h0, 6, 8'h01, 8'h01);
        pulse_start();
        send_stream(1'b1);
        wait_end(200);
        repeat (3) @(negedge clk);
        check("t5_done", 32'(done), 32'd1);
        check("t5_nwr", 32'(wa.size()), 32'd2);
        check("t5_ready_after", 32'(bus.in_ready_o), 32'd0);
        check_write(0, 32'h200, 32'h04030201, 4'hF);
        check_write(1, 32'h204, 32'h00000605, 4'h3);
        bus.in_valid_i = 1'b0;

        // Error response
        do_reset();
        acc_dly = 1;
        ack_dly = 1;
        ack_err = 1'b1;
        load_image(32'h0, 32'd4, 32'h0, 4, 8'h01, 8'h01);
        pulse_start();
        send_stream(1'b0);
        wait_end(100);
        repeat (2) @(negedge clk);
        check("t5b_error", 32'(err), 32'd1);
        check("t5b_done", 32'(done), 32'd0);
        check("t5b_core_rst", 32'(core_rst), 32'd1);
        check("t5b_nwr", 32'(wa.size()), 32'd1);
        ack_err = 1'b0;

        // Asynchronous reset while waiting for the ack, then a clean reload
        do_reset();
        acc_dly = 0;
        ack_dly = 3;
        load_image(32'h0, 32'd4, 32'h0, 4, 8'h01, 8'h01);
        pulse_start();
        send_stream(1'b0);
        begin
            int n = 0;
            while (wa.size() == 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("t6_write_seen", 32'(wa.size()), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t6");
        repeat (2) @(negedge clk);
        clear_log();
        rst_n   = 1'b1;
        ack_dly = 0;
        run_basic_image("t6r");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "timeout");
    end

endmodule
